ahb_lite_interconnect: RTL and testbench

Parametrised single-master AHB-lite interconnect for the MIPSfpga system bus. It decodes the master address phase onto N slaves using per-slave base/mask pairs and registers the selected slave for the data phase. It multiplexes HRDATA/HREADY/HRESP back from the selected slave, honours slave wait states, and answers unmapped accesses with a built-in default slave that issues a two-cycle AHB ERROR response. It replaces the fixed three-slave decoder/mux pair with hardwired HREADY=1 and HRESP=0.

---
 rtl/ahb_lite_pkg.sv | 26 ++
 rtl/ahb_default_slave.sv | 80 ++++++++
 rtl/ahb_lite_interconnect.sv | 129 ++++++++++++
 tb/tb_ahb_lite_interconnect.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-lite constants, default-slave state encoding and the MIPSfpga
// system memory map used to parameterise the interconnect.
package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      DS_OK   = 2'b00,
      DS_ERR1 = 2'b01,
      DS_ERR2 = 2'b10
   } ds_state_t;

   localparam logic [31:0] RAM_RESET_BASE = 32'h1fc0_0000;
   localparam logic [31:0] RAM_RESET_MASK = 32'h1fc0_0000;
   localparam logic [31:0] RAM_BASE       = 32'h0000_0000;
   localparam logic [31:0] RAM_MASK       = 32'h1000_0000;
   localparam logic [31:0] GPIO_BASE      = 32'h1f80_0000;
   localparam logic [31:0] GPIO_MASK      = 32'h1fc0_0000;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave answering unmapped accesses with a two-cycle ERROR response,
// plus sticky capture of the first offending address.
module ahb_default_slave
   import ahb_lite_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hready,
   input  logic              unmapped,
   input  logic [ADDR_W-1:0] haddr,
   input  logic              err_clr,
   output logic              ds_hready,
   output logic              ds_hresp,
   output logic              err_valid,
   output logic [ADDR_W-1:0] err_addr
);

   ds_state_t         state_r;
   ds_state_t         state_nx_s;
   logic              accept_err_s;
   logic              err_valid_r;
   logic [ADDR_W-1:0] err_addr_r;

   assign accept_err_s = hready & unmapped;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= DS_OK;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next state and response outputs
   always_comb begin
      state_nx_s = state_r;
      ds_hready  = 1'b1;
      ds_hresp   = HRESP_OKAY;
      case (state_r)
         DS_OK: begin
            if (accept_err_s) state_nx_s = DS_ERR1;
            else              state_nx_s = DS_OK;
         end
         DS_ERR1: begin
            ds_hready  = 1'b0;
            ds_hresp   = HRESP_ERROR;
            state_nx_s = DS_ERR2;
         end
         DS_ERR2: begin
            ds_hresp = HRESP_ERROR;
            if (accept_err_s) state_nx_s = DS_ERR1;
            else              state_nx_s = DS_OK;
         end
         default: begin
            state_nx_s = DS_OK;
         end
      endcase
   end

   // Sticky error capture; a new error outranks a coincident clear
   always_ff @(posedge clk) begin
      if (rst) begin
         err_valid_r <= 1'b0;
         err_addr_r  <= '0;
      end else if ((state_nx_s == DS_ERR1) && (!err_valid_r || err_clr)) begin
         err_valid_r <= 1'b1;
         err_addr_r  <= haddr;
      end else if (err_clr) begin
         err_valid_r <= 1'b0;
         err_addr_r  <= '0;
      end
   end

   assign err_valid = err_valid_r;
   assign err_addr  = err_addr_r;

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-lite interconnect: base/mask address decode, data-phase
// select register and response mux, with a built-in default slave.
module ahb_lite_interconnect
   import ahb_lite_pkg::*;
#(
   parameter int                           N_SLAVES = 4,
   parameter int                           ADDR_W   = 32,
   parameter int                           DATA_W   = 32,
   parameter logic [N_SLAVES*ADDR_W-1:0]   SLV_BASE = '0,
   parameter logic [N_SLAVES*ADDR_W-1:0]   SLV_MASK = '0
) (
   input  logic                         HCLK,
   input  logic                         HRESET,
   input  logic [ADDR_W-1:0]            HADDR,
   input  logic [1:0]                   HTRANS,
   input  logic                         HWRITE,
   input  logic [2:0]                   HSIZE,
   input  logic [DATA_W-1:0]            HWDATA,
   output logic [DATA_W-1:0]            HRDATA,
   output logic                         HREADY,
   output logic                         HRESP,
   output logic [N_SLAVES-1:0]          HSEL_S,
   output logic [ADDR_W-1:0]            HADDR_S,
   output logic [1:0]                   HTRANS_S,
   output logic                         HWRITE_S,
   output logic [2:0]                   HSIZE_S,
   output logic [DATA_W-1:0]            HWDATA_S,
   output logic                         HREADY_S,
   input  logic [N_SLAVES*DATA_W-1:0]   HRDATA_S,
   input  logic [N_SLAVES-1:0]          HREADYOUT_S,
   input  logic [N_SLAVES-1:0]          HRESP_S,
   output logic                         ERR_VALID,
   output logic [ADDR_W-1:0]            ERR_ADDR,
   input  logic                         ERR_CLR
);

   localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

   function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] mask);
      return ((addr & mask) == (base & mask)) && (mask != '0);
   endfunction

   logic [N_SLAVES-1:0] hsel_s;
   logic [IDX_W-1:0]    sel_idx_s;
   logic                sel_any_s;
   logic                trans_active_s;
   logic                unmapped_s;
   logic                dsel_def_r;
   logic [IDX_W-1:0]    dsel_idx_r;
   logic                ds_hready_s;
   logic                ds_hresp_s;

   // Address decode; scanning downward leaves the lowest hitting slot selected
   always_comb begin
      hsel_s    = '0;
      sel_idx_s = '0;
      sel_any_s = 1'b0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if (addr_hit(HADDR, SLV_BASE[i*ADDR_W +: ADDR_W], SLV_MASK[i*ADDR_W +: ADDR_W])) begin
            sel_idx_s = IDX_W'(i);
            sel_any_s = 1'b1;
         end else begin
            sel_idx_s = sel_idx_s;
         end
      end
      if (sel_any_s) hsel_s[sel_idx_s] = 1'b1;
      else           hsel_s = '0;
   end

   assign trans_active_s = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
   assign unmapped_s     = trans_active_s && !sel_any_s;

   // Data-phase select; IDLE/BUSY park on the default slave
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dsel_def_r <= 1'b1;
         dsel_idx_r <= '0;
      end else if (HREADY) begin
         if (trans_active_s && sel_any_s) begin
            dsel_def_r <= 1'b0;
            dsel_idx_r <= sel_idx_s;
         end else begin
            dsel_def_r <= 1'b1;
            dsel_idx_r <= '0;
         end
      end
   end

   // Response mux driven by the data-phase select
   always_comb begin
      HRDATA = '0;
      HREADY = 1'b1;
      HRESP  = HRESP_OKAY;
      if (dsel_def_r) begin
         HREADY = ds_hready_s;
         HRESP  = ds_hresp_s;
      end else begin
         HRDATA = HRDATA_S[dsel_idx_r*DATA_W +: DATA_W];
         HREADY = HREADYOUT_S[dsel_idx_r];
         HRESP  = HRESP_S[dsel_idx_r];
      end
   end

   assign HSEL_S   = hsel_s;
   assign HADDR_S  = HADDR;
   assign HTRANS_S = HTRANS;
   assign HWRITE_S = HWRITE;
   assign HSIZE_S  = HSIZE;
   assign HWDATA_S = HWDATA;
   assign HREADY_S = HREADY;

   ahb_default_slave #(
      .ADDR_W (ADDR_W)
   ) u_default_slave (
      .clk       (HCLK),
      .rst       (HRESET),
      .hready    (HREADY),
      .unmapped  (unmapped_s),
      .haddr     (HADDR),
      .err_clr   (ERR_CLR),
      .ds_hready (ds_hready_s),
      .ds_hresp  (ds_hresp_s),
      .err_valid (ERR_VALID),
      .err_addr  (ERR_ADDR)
   );

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Directed bench for ahb_lite_interconnect: slot 0 reset RAM, 1 RAM, 2 GPIO,
// 3 a low-region alias that overlaps slot 1.
module tb_ahb_lite_interconnect;
   import ahb_lite_pkg::*;

   localparam int N = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          HCLK;
   logic          HRESET;
   logic [AW-1:0] HADDR;
   logic [1:0]    HTRANS;
   logic          HWRITE;
   logic [2:0]    HSIZE;
   logic [DW-1:0] HWDATA;
   logic [DW-1:0] HRDATA;
   logic          HREADY;
   logic          HRESP;
   logic [N-1:0]  HSEL_S;
   logic [AW-1:0] HADDR_S;
   logic [1:0]    HTRANS_S;
   logic          HWRITE_S;
   logic [2:0]    HSIZE_S;
   logic [DW-1:0] HWDATA_S;
   logic          HREADY_S;
   logic [N*DW-1:0] HRDATA_S;
   logic [N-1:0]  HREADYOUT_S;
   logic [N-1:0]  HRESP_S;
   logic          ERR_VALID;
   logic [AW-1:0] ERR_ADDR;
   logic          ERR_CLR;

   int checks = 0;
   int errors = 0;

   ahb_lite_interconnect #(
      .N_SLAVES (N),
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .SLV_BASE ({32'h0000_0000, GPIO_BASE, RAM_BASE, RAM_RESET_BASE}),
      .SLV_MASK ({32'hf000_0000, GPIO_MASK, RAM_MASK, RAM_RESET_MASK})
   ) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HWRITE      (HWRITE),
      .HSIZE       (HSIZE),
      .HWDATA      (HWDATA),
      .HRDATA      (HRDATA),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .HSEL_S      (HSEL_S),
      .HADDR_S     (HADDR_S),
      .HTRANS_S    (HTRANS_S),
      .HWRITE_S    (HWRITE_S),
      .HSIZE_S     (HSIZE_S),
      .HWDATA_S    (HWDATA_S),
      .HREADY_S    (HREADY_S),
      .HRDATA_S    (HRDATA_S),
      .HREADYOUT_S (HREADYOUT_S),
      .HRESP_S     (HRESP_S),
      .ERR_VALID   (ERR_VALID),
      .ERR_ADDR    (ERR_ADDR),
      .ERR_CLR     (ERR_CLR)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      HRESET      = 1'b1;
      HADDR       = 32'h0;
      HTRANS      = HTRANS_IDLE;
      HWRITE      = 1'b0;
      HSIZE       = 3'b010;
      HWDATA      = 32'h0;
      HRDATA_S    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hdead_beef};
      HREADYOUT_S = 4'b1111;
      HRESP_S     = 4'b0000;
      ERR_CLR     = 1'b0;

      tick(); tick(); settle();
      chk("rst_hready", {31'd0, HREADY}, 32'd1);
      chk("rst_hresp", {31'd0, HRESP}, 32'd0);
      chk("rst_hrdata", HRDATA, 32'h0);
      chk("rst_err_valid", {31'd0, ERR_VALID}, 32'd0);
      chk("rst_err_addr", ERR_ADDR, 32'h0);
      HRESET = 1'b0;
      tick();

      // Zero-wait read from slave 0
      HADDR = 32'h1fc0_0010; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0;
      settle();
      chk("rd_hsel", {28'd0, HSEL_S}, 32'h1);
      chk("rd_haddr_s", HADDR_S, 32'h1fc0_0010);
      tick();
      HTRANS = HTRANS_IDLE;
      settle();
      chk("rd_hrdata", HRDATA, 32'hdead_beef);
      chk("rd_hready", {31'd0, HREADY}, 32'd1);
      chk("rd_hresp", {31'd0, HRESP}, 32'd0);

      // Write to slave 2 with three wait states
      HADDR = 32'h1f80_0000; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1;
      HREADYOUT_S = 4'b1011;
      settle();
      chk("wr_hsel", {28'd0, HSEL_S}, 32'h4);
      chk("wr_hwrite_s", {31'd0, HWRITE_S}, 32'd1);
      tick();
      HADDR = 32'h1fc0_0020; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HWDATA = 32'hcafe_f00d;
      settle();
      chk("wait1_hready", {31'd0, HREADY}, 32'd0);
      chk("wait1_hrdata", HRDATA, 32'h2222_2222);
      chk("wait1_hwdata_s", HWDATA_S, 32'hcafe_f00d);
      tick(); settle();
      chk("wait2_hready", {31'd0, HREADY}, 32'd0);
      tick(); settle();
      chk("wait3_hready", {31'd0, HREADY}, 32'd0);
      chk("wait3_haddr_s", HADDR_S, 32'h1fc0_0020);
      tick();
      HREADYOUT_S = 4'b1111;
      settle();
      chk("wait_end_hready", {31'd0, HREADY}, 32'd1);
      chk("wait_end_dsel", HRDATA, 32'h2222_2222);
      tick();
      HADDR = 32'h3000_0000; HTRANS = HTRANS_NONSEQ;
      settle();
      chk("held_rd_hrdata", HRDATA, 32'hdead_beef);
      chk("unm_hsel", {28'd0, HSEL_S}, 32'h0);

      // Single unmapped access
      tick();
      HTRANS = HTRANS_IDLE;
      settle();
      chk("unm_err1_hready", {31'd0, HREADY}, 32'd0);
      chk("unm_err1_hresp", {31'd0, HRESP}, 32'd1);
      chk("unm_hrdata", HRDATA, 32'h0);
      chk("unm_err_valid", {31'd0, ERR_VALID}, 32'd1);
      chk("unm_err_addr", ERR_ADDR, 32'h3000_0000);
      tick(); settle();
      chk("unm_err2_hready", {31'd0, HREADY}, 32'd1);
      chk("unm_err2_hresp", {31'd0, HRESP}, 32'd1);
      tick(); settle();
      chk("unm_ok_hready", {31'd0, HREADY}, 32'd1);
      chk("unm_ok_hresp", {31'd0, HRESP}, 32'd0);
      ERR_CLR = 1'b1;
      tick();
      ERR_CLR = 1'b0;
      settle();
      chk("clr_err_valid", {31'd0, ERR_VALID}, 32'd0);
      chk("clr_err_addr", ERR_ADDR, 32'h0);

      // Back-to-back unmapped accesses
      HADDR = 32'h3000_0000; HTRANS = HTRANS_NONSEQ;
      tick();
      HADDR = 32'h3000_0004;
      settle();
      chk("b2b_err1a_hready", {31'd0, HREADY}, 32'd0);
      chk("b2b_err1a_hresp", {31'd0, HRESP}, 32'd1);
      tick(); settle();
      chk("b2b_err2a_hready", {31'd0, HREADY}, 32'd1);
      chk("b2b_err2a_hresp", {31'd0, HRESP}, 32'd1);
      tick();
      HTRANS = HTRANS_IDLE;
      settle();
      chk("b2b_err1b_hready", {31'd0, HREADY}, 32'd0);
      chk("b2b_err1b_hresp", {31'd0, HRESP}, 32'd1);
      chk("b2b_err_addr", ERR_ADDR, 32'h3000_0000);
      tick(); settle();
      chk("b2b_err2b_hready", {31'd0, HREADY}, 32'd1);
      chk("b2b_err2b_hresp", {31'd0, HRESP}, 32'd1);
      tick();

      // Clear coinciding with a new error: the new error is latched
      HADDR = 32'h3000_0008; HTRANS = HTRANS_NONSEQ; ERR_CLR = 1'b1;
      tick();
      ERR_CLR = 1'b0; HTRANS = HTRANS_IDLE;
      settle();
      chk("coin_err_valid", {31'd0, ERR_VALID}, 32'd1);
      chk("coin_err_addr", ERR_ADDR, 32'h3000_0008);
      chk("coin_hready", {31'd0, HREADY}, 32'd0);
      tick(); tick();
      ERR_CLR = 1'b1;
      tick();
      ERR_CLR = 1'b0;
      settle();
      chk("clr2_err_valid", {31'd0, ERR_VALID}, 32'd0);

      // Overlapping slots 1 and 3
      HADDR = 32'h0000_0100; HTRANS = HTRANS_NONSEQ;
      settle();
      chk("ovl_hsel", {28'd0, HSEL_S}, 32'h2);
      tick();
      HTRANS = HTRANS_IDLE;
      settle();
      chk("ovl_hrdata", HRDATA, 32'h1111_1111);
      tick();

      // Reset while slave 1 holds a wait state
      HADDR = 32'h0000_0100; HTRANS = HTRANS_NONSEQ; HREADYOUT_S = 4'b1101;
      tick();
      HTRANS = HTRANS_IDLE;
      settle();
      chk("rstw_wait_hready", {31'd0, HREADY}, 32'd0);
      HRESET = 1'b1;
      tick(); settle();
      chk("rstw_hready", {31'd0, HREADY}, 32'd1);
      chk("rstw_hresp", {31'd0, HRESP}, 32'd0);
      chk("rstw_hrdata", HRDATA, 32'h0);
      HRESET = 1'b0;
      HREADYOUT_S = 4'b1111;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
